// File: rtl/sp_ram_arb2.sv
// Two-master round-robin arbiter in front of the single-port data RAM.
// One access per cycle, 1-cycle responses, per-port read-data hold registers.
module sp_ram_arb2 #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  logic                  ready_q;
  logic                  last_q, last_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [1:0]            isRead_q, isRead_d;
  logic [DATA_WIDTH-1:0] hold0_q, hold0_d;
  logic [DATA_WIDTH-1:0] hold1_q, hold1_d;
  logic                  gnt0, gnt1;

  // last_q names the port that won most recently; on a conflict the other one wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (ready_q) begin
      if (p0_req_i && p1_req_i) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = p0_req_i;
        gnt1 = p1_req_i;
      end
    end
  end

  assign p0_gnt_o = gnt0;
  assign p1_gnt_o = gnt1;
  assign ram_en_o = ready_q & (p0_req_i | p1_req_i);

  always_comb begin
    ram_addr_o  = p0_addr_i;
    ram_wdata_o = p0_wdata_i;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    if (gnt1) begin
      ram_addr_o  = p1_addr_i;
      ram_wdata_o = p1_wdata_i;
      ram_we_o    = p1_we_i;
      ram_be_o    = p1_be_i;
    end else if (gnt0) begin
      ram_we_o = p0_we_i;
      ram_be_o = p0_be_i;
    end
  end

  // Hold registers only follow read responses; write responses leave them alone.
  always_comb begin
    last_d      = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_q);
    rvalid_d    = {gnt1, gnt0};
    isRead_d    = isRead_q;
    isRead_d[0] = gnt0 ? ~p0_we_i : isRead_q[0];
    isRead_d[1] = gnt1 ? ~p1_we_i : isRead_q[1];
    hold0_d     = (rvalid_q[0] && isRead_q[0]) ? ram_rdata_i : hold0_q;
    hold1_d     = (rvalid_q[1] && isRead_q[1]) ? ram_rdata_i : hold1_q;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      ready_q  <= 1'b0;
      last_q   <= 1'b1;
      rvalid_q <= '0;
      isRead_q <= '0;
      hold0_q  <= '0;
      hold1_q  <= '0;
    end else begin
      ready_q  <= 1'b1;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      isRead_q <= isRead_d;
      hold0_q  <= hold0_d;
      hold1_q  <= hold1_d;
    end
  end

  assign p0_rvalid_o = rvalid_q[0];
  assign p1_rvalid_o = rvalid_q[1];
  assign p0_rdata_o  = (rvalid_q[0] && isRead_q[0]) ? ram_rdata_i : hold0_q;
  assign p1_rdata_o  = (rvalid_q[1] && isRead_q[1]) ? ram_rdata_i : hold1_q;

endmodule
